// File: rtl/mera_bus_pkg.sv
// rtl/mera_bus_pkg.sv - shared MERA-400 system-bus widths, idle levels and arbiter states
//
// Purpose: common definitions for sysbus_arb, mem_elwro_sram and later bus devices.
// Ports: none (package).
package mera_bus_pkg;

  localparam int NB_W = 4;
  localparam int AD_W = 16;
  localparam int DT_W = 16;

  // Bus lines are active low, so an undriven (idle) bus reads as all ones.
  localparam logic            CMD_IDLE = 1'b1;
  localparam logic [NB_W-1:0] NB_IDLE  = '1;
  localparam logic [AD_W-1:0] AD_IDLE  = '1;
  localparam logic [DT_W-1:0] DT_IDLE  = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin request picker
//
// Purpose: choose the first requesting channel at or after last+1 (mod CHANNELS).
// Ports:
//   req    in  CHANNELS  request vector, high = requesting
//   last   in  IDX_W     index of the most recently granted channel
//   valid  out 1         at least one request present
//   winner out IDX_W     chosen channel index (0 when valid is low)
module rr_pick #(
  parameter int CHANNELS = 2,
  parameter int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]    last,
  output logic                valid,
  output logic [IDX_W-1:0]    winner
);

  int unsigned      idx;
  logic [IDX_W-1:0] idx_w;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    // Walk the ring once starting just after the last winner; first hit wins.
    for (int k = 0; k < CHANNELS; k++) begin
      idx   = (int'(last) + 1 + k) % CHANNELS;
      idx_w = IDX_W'(idx);
      if (!valid && req[idx_w]) begin
        valid  = 1'b1;
        winner = idx_w;
      end
    end
  end

endmodule

// File: rtl/sysbus_arb.sv
// rtl/sysbus_arb.sv - round-robin system-bus arbiter and memory switch
//
// Purpose: grants the single memory module to one of CHANNELS bus masters at a
// time, routes the winner's command/address/data lines to memory and returns
// ok_/read data or a no-answer (en_) indication to the winner only.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   zg, zz                   per-master bus request / bus-in-use (hold grant)
//   zw                       per-master grant, one-hot or zero
//   m_w_, m_r_, m_s_         per-master write/read/special command (active low)
//   m_nb_, m_ad_, m_dt_      per-master block, address, write data (packed per channel)
//   m_ok_, m_en_             per-master acknowledge / no-answer (granted master only)
//   m_rdt_                   read data broadcast (all ones unless acknowledged)
//   w_, r_, s_, nb_, ad_, dt_ command and lines to memory
//   rok_, rdt_               memory acknowledge and read data
module sysbus_arb
  import mera_bus_pkg::*;
#(
  parameter int          CHANNELS      = 2,
  parameter logic [7:0]  TIMEOUT_TICKS = 8'd250
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      zg,
  input  logic [CHANNELS-1:0]      zz,
  output logic [CHANNELS-1:0]      zw,
  input  logic [CHANNELS-1:0]      m_w_,
  input  logic [CHANNELS-1:0]      m_r_,
  input  logic [CHANNELS-1:0]      m_s_,
  input  logic [NB_W*CHANNELS-1:0] m_nb_,
  input  logic [AD_W*CHANNELS-1:0] m_ad_,
  input  logic [DT_W*CHANNELS-1:0] m_dt_,
  output logic [CHANNELS-1:0]      m_ok_,
  output logic [CHANNELS-1:0]      m_en_,
  output logic [DT_W-1:0]          m_rdt_,
  output logic                     w_,
  output logic                     r_,
  output logic                     s_,
  output logic [NB_W-1:0]          nb_,
  output logic [AD_W-1:0]          ad_,
  output logic [DT_W-1:0]          dt_,
  input  logic                     rok_,
  input  logic [DT_W-1:0]          rdt_
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [CHANNELS-1:0] zw_q, zw_d;
  logic [7:0]          timer_q, timer_d;
  logic                en_q, en_d;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic                cmd_active;
  logic                ok_now;

  rr_pick #(
    .CHANNELS (CHANNELS),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req    (zg),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  assign cmd_active = !(m_w_[gnt_q] & m_r_[gnt_q] & m_s_[gnt_q]);

  // Acknowledge tracks rok_ directly while a command is on the bus; once a
  // command has timed out a late rok_ must not be reported as success.
  assign ok_now = !rok_ && ((state_q == ST_XFER) || (state_q == ST_DONE && !en_q));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    zw_d    = zw_q;
    timer_d = timer_q;
    en_d    = en_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          zw_d           = '0;
          zw_d[pick_idx] = 1'b1;
          gnt_d          = pick_idx;
          last_d         = pick_idx;
          state_d        = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Release is only evaluated here, so dropping zg mid-command is harmless.
        if (cmd_active) begin
          timer_d = '0;
          state_d = ST_XFER;
        end else if (!zg[gnt_q] && !zz[gnt_q]) begin
          zw_d    = '0;
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
        if (!rok_) begin
          state_d = ST_DONE;
        end else if (timer_q == TIMEOUT_TICKS - 8'd1) begin
          en_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!cmd_active) begin
          en_d    = 1'b0;
          state_d = ST_GRANT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(CHANNELS - 1);
      zw_q    <= '0;
      timer_q <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      zw_q    <= zw_d;
      timer_q <= timer_d;
      en_q    <= en_d;
    end
  end

  assign zw = zw_q;

  // Memory-side mux and master-side demux, steered by the registered grant.
  always_comb begin
    m_ok_  = '1;
    m_en_  = '1;
    m_rdt_ = DT_IDLE;
    w_     = CMD_IDLE;
    r_     = CMD_IDLE;
    s_     = CMD_IDLE;
    nb_    = NB_IDLE;
    ad_    = AD_IDLE;
    dt_    = DT_IDLE;
    if (state_q != ST_IDLE) begin
      w_  = m_w_[gnt_q];
      r_  = m_r_[gnt_q];
      s_  = m_s_[gnt_q];
      nb_ = m_nb_[int'(gnt_q)*NB_W +: NB_W];
      ad_ = m_ad_[int'(gnt_q)*AD_W +: AD_W];
      dt_ = m_dt_[int'(gnt_q)*DT_W +: DT_W];
    end
    if (ok_now) begin
      m_ok_[gnt_q] = 1'b0;
      m_rdt_       = rdt_;
    end
    if (en_q) begin
      m_en_[gnt_q] = 1'b0;
    end
  end

endmodule

// File: tb/tb_sysbus_arb.sv
// tb/tb_sysbus_arb.sv - self-checking bench for sysbus_arb
module tb_sysbus_arb;

  localparam int         CH  = 2;
  localparam logic [7:0] TMO = 8'd250;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] zg, zz, zw, m_w_, m_r_, m_s_, m_ok_, m_en_;
  logic [4*CH-1:0]  m_nb_;
  logic [16*CH-1:0] m_ad_, m_dt_;
  logic [15:0]   m_rdt_, ad_, dt_, rdt_;
  logic [3:0]    nb_;
  logic          w_, r_, s_, rok_;

  always #5 clk = ~clk;

  sysbus_arb #(.CHANNELS(CH), .TIMEOUT_TICKS(TMO)) dut (
    .clk(clk), .rst(rst), .zg(zg), .zz(zz), .zw(zw),
    .m_w_(m_w_), .m_r_(m_r_), .m_s_(m_s_),
    .m_nb_(m_nb_), .m_ad_(m_ad_), .m_dt_(m_dt_),
    .m_ok_(m_ok_), .m_en_(m_en_), .m_rdt_(m_rdt_),
    .w_(w_), .r_(r_), .s_(s_), .nb_(nb_), .ad_(ad_), .dt_(dt_),
    .rok_(rok_), .rdt_(rdt_)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  zg, zz, w_n, r_n;
    logic        rok_n;
    logic [1:0]  zw, ok, en;
    logic        w, r;
    logic [15:0] ad, rdt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [1:0] g, z, w, rd, input logic k,
                              input logic [1:0] ezw, eok, een, input logic ew, er,
                              input logic [15:0] ead, erdt);
    vec_t v;
    v.rst = r; v.zg = g; v.zz = z; v.w_n = w; v.r_n = rd; v.rok_n = k;
    v.zw = ezw; v.ok = eok; v.en = een; v.w = ew; v.r = er; v.ad = ead; v.rdt = erdt;
    return v;
  endfunction

  // Reference model: who owns the bus, whether a command is in flight, how
  // long it has waited and how it ended (0 pending, 1 acknowledged, 2 timed out).
  int owner, last_g, waited, result;
  bit in_cmd;

  function automatic bit idle_cmd(input int i);
    return m_w_[i] && m_r_[i] && m_s_[i];
  endfunction

  task automatic model_expect(output logic [63:0] e);
    logic [1:0] ezw, eok, een;
    logic [15:0] erdt, ead, edt;
    logic [3:0] enb;
    logic ew, er, es;
    ezw = '0; eok = '1; een = '1; erdt = '1; ead = '1; edt = '1; enb = '1;
    ew = 1'b1; er = 1'b1; es = 1'b1;
    if (owner >= 0) begin
      ezw[owner] = 1'b1;
      ew = m_w_[owner]; er = m_r_[owner]; es = m_s_[owner];
      enb = m_nb_[owner*4 +: 4];
      ead = m_ad_[owner*16 +: 16];
      edt = m_dt_[owner*16 +: 16];
      if (in_cmd && result != 2 && !rok_) begin
        eok[owner] = 1'b0;
        erdt = rdt_;
      end
      if (result == 2) een[owner] = 1'b0;
    end
    e = 64'({ezw, eok, een, erdt, ew, er, es, enb, ead, edt});
  endtask

  task automatic model_step();
    bit found;
    if (rst) begin
      owner = -1; last_g = CH - 1; in_cmd = 0; result = 0; waited = 0;
    end else if (owner < 0) begin
      found = 0;
      for (int k = 0; k < CH; k++) begin
        if (!found && zg[(last_g + 1 + k) % CH]) begin
          found = 1;
          owner = (last_g + 1 + k) % CH;
          last_g = owner;
        end
      end
    end else if (!in_cmd) begin
      if (!idle_cmd(owner)) begin
        in_cmd = 1; waited = 0; result = 0;
      end else if (!zg[owner] && !zz[owner]) begin
        owner = -1;
      end
    end else if (result == 0) begin
      if (!rok_) result = 1;
      else if (waited == int'(TMO) - 1) result = 2;
      waited++;
    end else if (idle_cmd(owner)) begin
      in_cmd = 0; result = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  vec_t tbl[23];
  logic [63:0] exp_v, act_v;
  int n;

  initial begin
    tbl[0]  = mk(0, 2'b00, 2'b00, 2'b11, 2'b11, 1, 2'b00, 2'b11, 2'b11, 1, 1, 16'hFFFF, 16'hFFFF);
    tbl[1]  = mk(0, 2'b01, 2'b00, 2'b11, 2'b11, 1, 2'b00, 2'b11, 2'b11, 1, 1, 16'hFFFF, 16'hFFFF);
    tbl[2]  = mk(0, 2'b01, 2'b00, 2'b11, 2'b10, 1, 2'b01, 2'b11, 2'b11, 1, 0, 16'h0100, 16'hFFFF);
    tbl[3]  = mk(0, 2'b01, 2'b00, 2'b11, 2'b10, 1, 2'b01, 2'b11, 2'b11, 1, 0, 16'h0100, 16'hFFFF);
    tbl[4]  = mk(0, 2'b01, 2'b00, 2'b11, 2'b10, 1, 2'b01, 2'b11, 2'b11, 1, 0, 16'h0100, 16'hFFFF);
    tbl[5]  = mk(0, 2'b01, 2'b00, 2'b11, 2'b10, 1, 2'b01, 2'b11, 2'b11, 1, 0, 16'h0100, 16'hFFFF);
    tbl[6]  = mk(0, 2'b01, 2'b00, 2'b11, 2'b10, 0, 2'b01, 2'b10, 2'b11, 1, 0, 16'h0100, 16'h1234);
    tbl[7]  = mk(0, 2'b01, 2'b00, 2'b11, 2'b10, 0, 2'b01, 2'b10, 2'b11, 1, 0, 16'h0100, 16'h1234);
    tbl[8]  = mk(0, 2'b01, 2'b00, 2'b11, 2'b11, 1, 2'b01, 2'b11, 2'b11, 1, 1, 16'h0100, 16'hFFFF);
    tbl[9]  = mk(0, 2'b00, 2'b00, 2'b11, 2'b11, 1, 2'b01, 2'b11, 2'b11, 1, 1, 16'h0100, 16'hFFFF);
    tbl[10] = mk(0, 2'b00, 2'b00, 2'b11, 2'b11, 1, 2'b00, 2'b11, 2'b11, 1, 1, 16'hFFFF, 16'hFFFF);
    tbl[11] = mk(1, 2'b00, 2'b00, 2'b11, 2'b11, 1, 2'b00, 2'b11, 2'b11, 1, 1, 16'hFFFF, 16'hFFFF);
    tbl[12] = mk(0, 2'b11, 2'b00, 2'b11, 2'b11, 1, 2'b00, 2'b11, 2'b11, 1, 1, 16'hFFFF, 16'hFFFF);
    tbl[13] = mk(0, 2'b11, 2'b00, 2'b11, 2'b11, 1, 2'b01, 2'b11, 2'b11, 1, 1, 16'h0100, 16'hFFFF);
    tbl[14] = mk(0, 2'b10, 2'b00, 2'b11, 2'b11, 1, 2'b01, 2'b11, 2'b11, 1, 1, 16'h0100, 16'hFFFF);
    tbl[15] = mk(0, 2'b10, 2'b00, 2'b11, 2'b11, 1, 2'b00, 2'b11, 2'b11, 1, 1, 16'hFFFF, 16'hFFFF);
    tbl[16] = mk(0, 2'b11, 2'b00, 2'b11, 2'b11, 1, 2'b10, 2'b11, 2'b11, 1, 1, 16'h0200, 16'hFFFF);
    tbl[17] = mk(0, 2'b01, 2'b00, 2'b11, 2'b11, 1, 2'b10, 2'b11, 2'b11, 1, 1, 16'h0200, 16'hFFFF);
    tbl[18] = mk(0, 2'b11, 2'b00, 2'b11, 2'b11, 1, 2'b00, 2'b11, 2'b11, 1, 1, 16'hFFFF, 16'hFFFF);
    tbl[19] = mk(0, 2'b11, 2'b00, 2'b11, 2'b11, 1, 2'b01, 2'b11, 2'b11, 1, 1, 16'h0100, 16'hFFFF);
    tbl[20] = mk(0, 2'b11, 2'b00, 2'b01, 2'b11, 1, 2'b01, 2'b11, 2'b11, 1, 1, 16'h0100, 16'hFFFF);
    tbl[21] = mk(0, 2'b00, 2'b00, 2'b11, 2'b11, 1, 2'b01, 2'b11, 2'b11, 1, 1, 16'h0100, 16'hFFFF);
    tbl[22] = mk(0, 2'b00, 2'b00, 2'b11, 2'b11, 1, 2'b00, 2'b11, 2'b11, 1, 1, 16'hFFFF, 16'hFFFF);

    rst = 1'b1; zg = '0; zz = '0; m_w_ = '1; m_r_ = '1; m_s_ = '1; rok_ = 1'b1;
    m_nb_ = {4'h2, 4'h1}; m_ad_ = {16'h0200, 16'h0100}; m_dt_ = {16'h5555, 16'hAAAA};
    rdt_ = 16'h1234;
    cyc();
    cyc();

    for (int i = 0; i < 23; i++) begin
      rst = tbl[i].rst; zg = tbl[i].zg; zz = tbl[i].zz;
      m_w_ = tbl[i].w_n; m_r_ = tbl[i].r_n; rok_ = tbl[i].rok_n;
      #1;
      act_v = 64'({zw, m_ok_, m_en_, w_, r_, ad_, m_rdt_});
      exp_v = 64'({tbl[i].zw, tbl[i].ok, tbl[i].en, tbl[i].w, tbl[i].r, tbl[i].ad, tbl[i].rdt});
      check($sformatf("table_row%0d", i), act_v, exp_v);
      cyc();
    end

    // ch1 write that memory never answers.
    zg = 2'b10; m_w_ = 2'b01; rok_ = 1'b1;
    cyc();
    cyc();
    n = 0;
    while (m_en_[1] === 1'b1 && n < 400) begin
      cyc();
      n++;
    end
    check("timeout_latency", 64'(n), 64'd250);
    check("timeout_state", 64'({zw, m_en_, m_ok_, w_}), 64'({2'b10, 2'b01, 2'b11, 1'b0}));
    m_w_ = 2'b11;
    cyc();
    check("timeout_clear", 64'({zw, m_en_}), 64'({2'b10, 2'b11}));
    zg = 2'b00;
    cyc();
    check("timeout_release", 64'(zw), 64'(2'b00));

    // ch0 drops zg but holds zz across a read.
    zg = 2'b01; m_r_ = 2'b10;
    cyc();
    cyc();
    zg = 2'b00; zz = 2'b01;
    cyc();
    check("zz_hold_xfer", 64'({zw, r_}), 64'({2'b01, 1'b0}));
    rok_ = 1'b0;
    cyc();
    check("zz_hold_done", 64'({zw, m_ok_}), 64'({2'b01, 2'b10}));
    m_r_ = 2'b11; rok_ = 1'b1;
    cyc();
    check("zz_hold_grant", 64'(zw), 64'(2'b01));
    cyc();
    check("zz_hold_grant2", 64'(zw), 64'(2'b01));
    zz = 2'b00;
    cyc();
    check("zz_release", 64'(zw), 64'(2'b00));

    // Reset in the middle of a ch0 read, with rok_ still low.
    zg = 2'b01; m_r_ = 2'b10;
    cyc();
    cyc();
    check("rst_pre_xfer", 64'({zw, r_}), 64'({2'b01, 1'b0}));
    rok_ = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0; zg = 2'b11; m_r_ = 2'b11; rok_ = 1'b1;
    #1;
    check("rst_outputs", 64'({zw, m_ok_, m_en_, w_, r_, s_, nb_, ad_, dt_, m_rdt_}),
          64'({2'b00, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 4'hF, 16'hFFFF, 16'hFFFF, 16'hFFFF}));
    cyc();
    check("rst_first_grant", 64'(zw), 64'(2'b01));
    zg = 2'b00;
    cyc();
    cyc();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      int sel;
      rst = (c == 0) || ($urandom_range(0, 299) == 0);
      for (int i = 0; i < CH; i++) begin
        zg[i] = ($urandom_range(0, 9) < 6);
        zz[i] = ($urandom_range(0, 9) < 3);
        sel = int'($urandom_range(0, 7));
        m_w_[i] = (sel != 0);
        m_r_[i] = (sel != 1);
        m_s_[i] = (sel != 2);
      end
      m_nb_ = 8'($urandom);
      m_ad_ = $urandom;
      m_dt_ = $urandom;
      rdt_  = 16'($urandom);
      rok_  = ($urandom_range(0, 3) != 0);
      #1;
      if (c > 0) begin
        model_expect(exp_v);
        act_v = 64'({zw, m_ok_, m_en_, m_rdt_, w_, r_, s_, nb_, ad_, dt_});
        check($sformatf("random_cycle%0d", c), act_v, exp_v);
      end
      model_step();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sysbus_arb.md
# sysbus_arb

Multi-channel system-bus arbiter and switch for the MERA-400 FPGA system. Accepts bus reservation requests (zg) from up to CHANNELS bus masters (CPUs, later a channel/DMA unit), grants one at a time (zw) with round-robin fairness, and routes the winner's active-low command/address/data lines to the single memory module. It returns ok_ and read data only to the granted master, and raises en_ (no answer) when memory fails to respond within TIMEOUT_TICKS. It replaces the single-CPU hookup where zw is tied to zg and ren_ is tied inactive.

## Interface
- CHANNELS, 2: number of bus masters, 1..8.
- TIMEOUT_TICKS, 8'd250: clk cycles a command may wait for rok_ before en_ is asserted.
- clk  in  1  system clock, CLK_EXT domain.
- rst  in  1  reset; one clock, synchronous, active-high.
- zg  in  CHANNELS  per-master bus request, high = wants bus.
- zz  in  CHANNELS  per-master "bus in use", high = grant must not be revoked.
- zw  out  CHANNELS  per-master grant, one-hot or zero.
- m_w_, m_r_, m_s_  in  CHANNELS each  per-master write/read/special command, active low.
- m_nb_  in  4*CHANNELS  per-master block number, channel i at [4i+3:4i].
- m_ad_  in  16*CHANNELS  per-master address.
- m_dt_  in  16*CHANNELS  per-master write data.
- m_ok_  out  CHANNELS  memory acknowledge, granted master only.
- m_en_  out  CHANNELS  no-answer indication, granted master only.
- m_rdt_  out  16  read data broadcast, all 1s unless the granted master's command is acknowledged.
- w_, r_, s_  out  1 each  command to memory.
- nb_  out  4; ad_  out  16; dt_  out  16  block/address/data to memory.
- rok_  in  1  memory acknowledge; rdt_  in  16  memory read data.

## Operation
- All *_ lines are active low; an inactive bus is all 1s.
- FSM states: IDLE, GRANT, XFER, DONE.
- IDLE: if any zg, pick the winner by round robin, starting at last_granted+1 mod CHANNELS. Register zw[winner]=1 and go to GRANT.
- GRANT: if the winner's command is active (any of m_w_/m_r_/m_s_ low), go to XFER and clear the timer. Else, if zg[winner]=0 and zz[winner]=0, drop zw and go to IDLE.
- XFER: memory sees the winner's lines. If rok_=0, m_ok_[winner]=0 and m_rdt_=rdt_; go to DONE. If the timer reaches TIMEOUT_TICKS-1 without rok_, m_en_[winner]=0; go to DONE.
- DONE: hold ok_/en_ until the winner releases its command (all three high), then return to GRANT. m_ok_ follows rok_ combinationally and may deassert earlier.
- Routing to memory is combinational from the registered grant index. In IDLE, all memory-side outputs are inactive (1s).
- Ungranted masters always see m_ok_=1 and m_en_=1.
- Commands from non-granted masters are ignored; they cannot reach memory.
- A zg drop during XFER/DONE does not revoke the grant; release is evaluated only in GRANT.
- CHANNELS=1 degenerates to the existing direct connection plus timeout.

## Timing
- Reset: state IDLE; zw=0; m_ok_, m_en_ all 1; m_rdt_, w_, r_, s_, nb_, ad_, dt_ all 1s; last_granted=CHANNELS-1, so channel 0 wins first; timer=0.
- Grant latency: zg rises in cycle t, zw rises at the edge ending t (visible in t+1).
- Release: zg and zz low in cycle t in GRANT, zw falls at t+1. A pending request is granted at t+2, so there is one dead bus cycle, and the grant passes to another channel if one is requesting.
- Simultaneous requests: the lowest index at or after last_granted+1 wins. A channel that still requests after release waits at most CHANNELS-1 grants.
- Timer: increments once per cycle in XFER, saturating; en_ asserts exactly TIMEOUT_TICKS cycles after XFER entry.
- rok_ and timeout in the same cycle: ok wins, en_ stays 1.
- rst mid-transfer: all outputs go inactive at the next edge; no partial handshake is completed.

## Structure
- Package mera_bus_pkg holds NB_W=4, AD_W=16, DT_W=16, the arbiter state enum, and the all-ones inactive constants. These are shared with mem_elwro_sram and future bus devices.
- Sub-module rr_pick: combinational CHANNELS-wide round-robin picker (inputs req vector and last index; outputs valid and winner index).
- Top sysbus_arb: FSM, timer, grant register, mux/demux.

## Test plan
- Reset, then zg=01 (ch0) → zw=01 next cycle; ch0 read at ad_=16'h0100 with rok_ after 3 cycles → m_ok_[0]=0, m_rdt_=rdt_, m_ok_[1]=1.
- zg=11 simultaneously from reset → ch0 granted. After ch0 releases (zg0=0, zz0=0) → zw=00 for one cycle, then 10. Next contention → ch0 again.
- No rok_ on ch1 write → m_en_[1]=0 exactly 250 cycles after XFER entry; it clears on command release; zw is kept.
- ch1 asserts m_w_=0 while ch0 is granted → w_ stays 1, ad_ shows ch0's address only.
- ch0 drops zg with zz=1 mid-XFER → grant held through DONE. After zz falls, zw drops on the next edge.
- rst pulse during XFER → next cycle zw=0, all bus outputs 1s; a subsequent request starts from channel 0.
